// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN streaming layers: pixel phase encoding,
// signed max, channel slice offsets and counter widths.
package cnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int MAX_SAMPLE_WIDTH   = 64;

  typedef logic signed [MAX_SAMPLE_WIDTH-1:0] wide_t;

  // {row parity, column parity} of the pixel being accepted
  typedef enum logic [1:0] {
    PH_EVEN_EVEN = 2'b00,
    PH_EVEN_ODD  = 2'b01,
    PH_ODD_EVEN  = 2'b10,
    PH_ODD_ODD   = 2'b11
  } phase_t;

  function automatic logic signed_ge(input wide_t a, input wide_t b);
    return a >= b;
  endfunction

  function automatic wide_t smax(input wide_t a, input wide_t b);
    return signed_ge(a, b) ? a : b;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic int count_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/relu_maxpool_stream_pool_lane.sv
// One channel of the pooling stage: optional ReLU (RELU_EN), window hold register,
// half-width line buffer with registered read, and the 2x2 max output register.
module pool_lane
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int HALF_WIDTH = 16,
  parameter int ADDR_WIDTH = addr_width(HALF_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  frame_start,
  input  logic                  valid_in,
  input  phase_t                phase,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic signed [DATA_WIDTH-1:0] s;
  logic signed [DATA_WIDTH-1:0] hold_reg;
  logic signed [DATA_WIDTH-1:0] rd_reg;
  logic signed [DATA_WIDTH-1:0] out_reg;
  logic signed [DATA_WIDTH-1:0] pair_max;
  logic signed [DATA_WIDTH-1:0] quad_max;
  logic signed [DATA_WIDTH-1:0] line_buf [0:(1<<ADDR_WIDTH)-1];

  always_comb begin
`ifdef RELU_EN
    s = sample[DATA_WIDTH-1] ? '0 : $signed(sample);
`else
    s = $signed(sample);
`endif
    pair_max = signed_ge(wide_t'(hold_reg), wide_t'(s)) ? hold_reg : s;
    quad_max = signed_ge(wide_t'(pair_max), wide_t'(rd_reg)) ? pair_max : rd_reg;
  end

  // The upper-row pair max is fetched while the lower row's even pixel is
  // accepted, so the odd pixel finds it already registered.
  always_ff @(posedge clk) begin
    if (valid_in && phase == PH_EVEN_ODD) line_buf[addr] <= pair_max;
    if (valid_in && phase == PH_ODD_EVEN) rd_reg <= line_buf[addr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_reg <= '0;
      out_reg  <= '0;
    end else if (valid_in) begin
      case (phase)
        PH_EVEN_EVEN, PH_ODD_EVEN: hold_reg <= s;
        PH_ODD_ODD:                out_reg  <= quad_max;
        default: ;
      endcase
    end else if (frame_start) begin
      hold_reg <= '0;
    end
  end

  assign data_out = out_reg;

endmodule

// File: rtl/relu_maxpool_stream.sv
// ReLU + 2x2/stride-2 max pooling over CHANNEL packed feature maps in raster order.
// Define RELU_EN to clamp negative samples to zero before pooling.
module relu_maxpool_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CHANNEL    = 4,
  parameter int WIDTH      = 32,
  parameter int HEIGHT     = 32
) (
  input  logic                                          clk,
  input  logic                                          resetn,
  input  logic                                          frame_start,
  input  logic                                          valid_in,
  input  logic [CHANNEL*DATA_WIDTH-1:0]                 data_in,
  output logic [CHANNEL*DATA_WIDTH-1:0]                 data_out,
  output logic                                          valid_out,
  output logic                                          frame_done,
  output logic [count_width((WIDTH/2)*(HEIGHT/2))-1:0]  out_count
);

  localparam int HALF  = WIDTH / 2;
  localparam int TOTAL = (WIDTH / 2) * (HEIGHT / 2);
  localparam int CW    = addr_width(WIDTH);
  localparam int RW    = addr_width(HEIGHT);
  localparam int AW    = addr_width(HALF);
  localparam int OW    = count_width(TOTAL);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(TOTAL - 1);

  logic [CW-1:0] col_reg, col_eff;
  logic [RW-1:0] row_reg, row_eff;
  logic [OW-1:0] count_reg;
  logic          valid_reg, done_reg;
  logic          col_wrap, emit;
  phase_t        phase;
  logic [AW-1:0] addr;

  // A frame_start pixel is treated as (0,0) of the new frame.
  always_comb begin
    col_eff  = frame_start ? '0 : col_reg;
    row_eff  = frame_start ? '0 : row_reg;
    col_wrap = (col_eff == COL_LAST);
    phase    = phase_t'({row_eff[0], col_eff[0]});
    addr     = AW'(col_eff >> 1);
    emit     = valid_in && (phase == PH_ODD_ODD);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_reg   <= '0;
      row_reg   <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      if (valid_in) begin
        col_reg <= col_wrap ? '0 : col_eff + CW'(1);
        if (col_wrap) row_reg <= (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
        else          row_reg <= row_eff;
      end else if (frame_start) begin
        col_reg <= '0;
        row_reg <= '0;
      end
      valid_reg <= emit;
      done_reg  <= emit && (count_reg == OUT_LAST);
      if (frame_start)   count_reg <= '0;
      else if (emit)     count_reg <= count_reg + OW'(1);
      else if (done_reg) count_reg <= '0;
    end
  end

  for (genvar gi = 0; gi < CHANNEL; gi++) begin : g_lane
    pool_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .HALF_WIDTH (HALF),
      .ADDR_WIDTH (AW)
    ) u_lane (
      .clk         (clk),
      .resetn      (resetn),
      .frame_start (frame_start),
      .valid_in    (valid_in),
      .phase       (phase),
      .addr        (addr),
      .sample      (data_in[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
      .data_out    (data_out[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  assign valid_out  = valid_reg;
  assign frame_done = done_reg;
  assign out_count  = count_reg;

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Self-checking bench: odd-sized 7x5x4 frames against a window-level reference model.
module tb_relu_maxpool_stream;
  import cnn_pkg::*;

  localparam int DW    = 16;
  localparam int CH    = 4;
  localparam int W     = 7;
  localparam int H     = 5;
  localparam int TOTAL = (W / 2) * (H / 2);
  localparam int OW    = count_width(TOTAL);

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              frame_start = 1'b0;
  logic              valid_in = 1'b0;
  logic [CH*DW-1:0]  data_in = '0;
  logic [CH*DW-1:0]  data_out;
  logic              valid_out;
  logic              frame_done;
  logic [OW-1:0]     out_count;

  relu_maxpool_stream #(
    .DATA_WIDTH (DW), .CHANNEL (CH), .WIDTH (W), .HEIGHT (H)
  ) dut (
    .clk (clk), .resetn (resetn), .frame_start (frame_start), .valid_in (valid_in),
    .data_in (data_in), .data_out (data_out), .valid_out (valid_out),
    .frame_done (frame_done), .out_count (out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH*DW-1:0] data;
    bit               last;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  int                checks = 0;
  int                errors = 0;
  int                exp_count = 0;
  int                exp_done = 0;
  int                seen_done = 0;
  bit                prev_done = 0;
  bit                got_first = 0;
  logic [CH*DW-1:0]  first_out = '0;
  logic signed [DW-1:0] frm [H][W][CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic signed [DW-1:0] act(input logic signed [DW-1:0] v);
`ifdef RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Fill a frame and queue every pooled pixel whose 2x2 window is complete
  // within the first n pixels sent.
  task automatic build(input int mode, input int n);
    exp_t e;
    logic signed [DW-1:0] m, v;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int ch = 0; ch < CH; ch++) begin
          case (mode)
            0:       frm[r][c][ch] = DW'((r*W + c + 1) * (ch + 1));
            1:       frm[r][c][ch] = DW'(-((r*W + c + 1) * (ch + 1)));
            default: frm[r][c][ch] = DW'($urandom);
          endcase
        end
    for (int pr = 0; pr < H/2; pr++)
      for (int pc = 0; pc < W/2; pc++) begin
        if ((2*pr + 1) * W + 2*pc + 1 < n) begin
          for (int ch = 0; ch < CH; ch++) begin
            m = act(frm[2*pr][2*pc][ch]);
            for (int d = 1; d < 4; d++) begin
              v = act(frm[2*pr + d/2][2*pc + d%2][ch]);
              if (v > m) m = v;
            end
            e.data[ch*DW +: DW] = m;
          end
          e.last = (pr == H/2 - 1) && (pc == W/2 - 1);
          if (e.last) exp_done++;
          exp_q.push_back(e);
        end
      end
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic send(input int mode, input int n, input bit fs, input int gap_pct);
    build(mode, n);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
        @(posedge clk); #1;
      end
      for (int ch = 0; ch < CH; ch++) data_in[ch*DW +: DW] = frm[i / W][i % W][ch];
      valid_in    = 1'b1;
      frame_start = fs && (i == 0);
      @(posedge clk); #1;
      valid_in    = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (prev_done) check("count_clear", 64'(out_count), 64'd0);
      prev_done = 0;
      if (valid_out) begin
        exp_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(valid_out), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("data_out", data_out, mon_e.data);
          check("frame_done", 64'(frame_done), 64'(mon_e.last));
          check("out_count", 64'(out_count), 64'(exp_count));
          if (!got_first) begin
            first_out = data_out;
            got_first = 1;
          end
          if (mon_e.last) begin
            exp_count = 0;
            prev_done = 1;
          end
        end
      end else if (frame_done) begin
        check("stray_done", 64'(frame_done), 64'd0);
      end
      if (frame_done) seen_done++;
      if (frame_start) exp_count = 0;
    end else begin
      exp_count = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    send(0, W*H, 1'b1, 0);          // ramp frame, first pixel tagged frame_start
    send(1, W*H, 1'b0, 0);          // negated frame via auto-wrap
    repeat (3) @(posedge clk); #1;
    check("first_lane0", 64'(first_out[0 +: DW]), 64'd9);
    check("first_lane3", 64'(first_out[3*DW +: DW]), 64'd36);

    for (int f = 0; f < 3; f++) send(2, W*H, f == 0, 50);

    send(2, 10, 1'b0, 0);           // partial frame aborted by reset
    repeat (3) @(posedge clk); #1;
    check("pre_rst_count", 64'(out_count), 64'd1);
    resetn = 1'b0;
    #1;
    check("async_rst_count", 64'(out_count), 64'd0);
    check("async_rst_data", data_out, 64'd0);
    @(posedge clk); #1;
    check("rst_hold_valid", 64'(valid_out), 64'd0);
    resetn = 1'b1;
    send(2, W*H, 1'b0, 30);

    send(2, 9, 1'b0, 0);            // partial frame cut by frame_start
    send(2, W*H, 1'b1, 0);
    send(2, W*H, 1'b0, 50);

    repeat (5) @(posedge clk); #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(seen_done), 64'(exp_done));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
